pwm_multi_channel: RTL and testbench

Parametrised N-channel PWM generator; successor to the single-channel 8-bit PWM block. Uses one shared timebase, per-channel double-buffered duty registers and a selectable edge- or centre-aligned mode. Duty changes take effect only at period boundaries, so there are no glitched pulses. Sits between the sample/sine-table logic (duty writer) and the output pins/filters.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_timebase.sv | 65 ++++++
 rtl/pwm_multi_channel.sv | 75 +++++++
 tb/tb_pwm_multi_channel.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam int MODE_EDGE   = 0;
  localparam int MODE_CENTER = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Select-bus width that stays at least one bit wide for a single channel.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: sawtooth (edge mode) or up/down triangle (centre mode),
// with a combinational strobe marking the tick that ends a period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int CENTER_ALIGNED = MODE_EDGE
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  output logic [WIDTH-1:0] cnt,
  output logic             reload
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  dir_e             dir;
  dir_e             dir_next;
  logic [WIDTH-1:0] cnt_next;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    cnt_next = cnt;
    dir_next = dir;
    reload   = 1'b0;
    if (CE) begin
      if (CENTER_ALIGNED == MODE_CENTER) begin
        if (dir == DIR_UP) begin
          if (cnt == MAX) begin
            cnt_next = MAX - ONE;
            dir_next = DIR_DOWN;
          end else begin
            cnt_next = cnt + ONE;
          end
        end else begin
          cnt_next = cnt - ONE;
          if (cnt == ONE) begin
            dir_next = DIR_UP;
            reload   = 1'b1;
          end
        end
      end else begin
        // Natural wrap from MAX to 0 closes the sawtooth period.
        cnt_next = cnt + ONE;
        reload   = (cnt == MAX);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator: shared timebase, double-buffered duty registers
// that swap only at period boundaries, and registered compare outputs.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int CHANNELS       = 4,
  parameter int CENTER_ALIGNED = MODE_EDGE
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                CE,
  input  logic                                D_WR,
  input  logic [clog2_min1(CHANNELS)-1:0]     D_SEL,
  input  logic [WIDTH-1:0]                    D,
  output logic [CHANNELS-1:0]                 PWM,
  output logic                                PERIOD_START
);

  typedef logic [WIDTH-1:0] duty_t;

  duty_t            shadow [CHANNELS];
  duty_t            active [CHANNELS];
  logic [WIDTH-1:0] cnt;
  logic             reload;
  logic             sel_ok;

  pwm_timebase #(
    .WIDTH          (WIDTH),
    .CENTER_ALIGNED (CENTER_ALIGNED)
  ) u_timebase (
    .CLK    (CLK),
    .RST    (RST),
    .CE     (CE),
    .cnt    (cnt),
    .reload (reload)
  );

  // Out-of-range selects are dropped so they cannot alias onto a real channel.
  assign sel_ok = (int'(D_SEL) < CHANNELS);

  // NOTE: the duty arrays are reset explicitly because a freshly reset block
  // must produce 0% duty on every channel; they stay small flop arrays.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (D_WR && sel_ok) begin
        shadow[D_SEL] <= D;
      end
      // A write on the reload edge lands in shadow; active takes the old value.
      if (reload) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PWM          <= '0;
      PERIOD_START <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        PWM[i] <= (cnt < active[i]);
      end
      PERIOD_START <= reload;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench: edge, centre and six-channel instances share stimulus
// and are compared each cycle against a tick-count reference model.
`timescale 1ns/1ps
module tb_pwm_multi_channel;

  localparam int ND = 3;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b0;
  logic       CE    = 1'b0;
  logic       D_WR  = 1'b0;
  logic [2:0] sel   = '0;
  logic [7:0] D     = '0;

  logic [3:0] pwm_e, pwm_c;
  logic [5:0] pwm_x;
  logic       ps_e, ps_c, ps_x;

  pwm_multi_channel #(.WIDTH(8), .CHANNELS(4), .CENTER_ALIGNED(0)) dut_e (
    .CLK(CLK), .RST(RST), .CE(CE), .D_WR(D_WR), .D_SEL(sel[1:0]), .D(D),
    .PWM(pwm_e), .PERIOD_START(ps_e));

  pwm_multi_channel #(.WIDTH(8), .CHANNELS(4), .CENTER_ALIGNED(1)) dut_c (
    .CLK(CLK), .RST(RST), .CE(CE), .D_WR(D_WR), .D_SEL(sel[1:0]), .D(D),
    .PWM(pwm_c), .PERIOD_START(ps_c));

  pwm_multi_channel #(.WIDTH(8), .CHANNELS(6), .CENTER_ALIGNED(0)) dut_x (
    .CLK(CLK), .RST(RST), .CE(CE), .D_WR(D_WR), .D_SEL(sel), .D(D),
    .PWM(pwm_x), .PERIOD_START(ps_x));

  always #5 CLK = ~CLK;

  logic [5:0] pwm_o [ND];
  logic       ps_o  [ND];
  assign pwm_o[0] = {2'b00, pwm_e};
  assign pwm_o[1] = {2'b00, pwm_c};
  assign pwm_o[2] = pwm_x;
  assign ps_o[0]  = ps_e;
  assign ps_o[1]  = ps_c;
  assign ps_o[2]  = ps_x;

  // Reference model: position inside the period is a plain tick count.
  int         nch [ND] = '{4, 4, 6};
  int         cen [ND] = '{0, 1, 0};
  int         per [ND] = '{256, 510, 256};
  int         ticks [ND];
  int         sh  [ND][6];
  int         act [ND][6];
  logic [5:0] exp_pwm [ND];
  logic       exp_ps  [ND];

  int checks   = 0;
  int failures = 0;
  bit ce_tog   = 1'b0;

  task automatic check(input string tag, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act_v, exp_v, $time);
    end
  endtask

  function automatic int cnt_of(input int d, input int t);
    if (cen[d] != 0) return (t <= 255) ? t : 510 - t;
    return t;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      ticks[d]   = 0;
      exp_pwm[d] = '0;
      exp_ps[d]  = 1'b0;
      for (int i = 0; i < 6; i++) begin
        sh[d][i]  = 0;
        act[d][i] = 0;
      end
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      int  c;
      int  idx;
      bit  rl;
      c = cnt_of(d, ticks[d]);
      for (int i = 0; i < 6; i++)
        exp_pwm[d][i] = (i < nch[d]) && (c < act[d][i]);
      rl = CE && (((ticks[d] + 1) % per[d]) == 0);
      exp_ps[d] = rl;
      if (CE) ticks[d] = (ticks[d] + 1) % per[d];
      if (rl)
        for (int i = 0; i < 6; i++) act[d][i] = sh[d][i];
      idx = (d < 2) ? int'(sel[1:0]) : int'(sel);
      if (D_WR && idx < nch[d]) sh[d][idx] = int'(D);
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the negedge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("pwm%0d", d), int'(pwm_o[d]), int'(exp_pwm[d]));
      check($sformatf("ps%0d", d), int'(ps_o[d]), int'(exp_ps[d]));
    end
    if (ce_tog) CE = ~CE;
  endtask

  task automatic wr(input int s, input int v);
    sel  = 3'(s);
    D    = 8'(v);
    D_WR = 1'b1;
    step();
    D_WR = 1'b0;
  endtask

  task automatic wait_ticks(input int d, input int t, input string tag);
    int n = 0;
    while (ticks[d] != t && n < 1200) begin
      step();
      n++;
    end
    check({tag, "_reach"}, ticks[d], t);
  endtask

  task automatic wait_ps(input int d, input string tag);
    int n = 0;
    while (!ps_o[d] && n < 1200) begin
      step();
      n++;
    end
    check({tag, "_ps_seen"}, int'(ps_o[d]), 1);
  endtask

  // Skip one whole period so the next window uses a settled duty.
  task automatic sync(input int d, input string tag);
    wait_ps(d, tag);
    step();
    wait_ps(d, tag);
  endtask

  // Measure PERIOD_START spacing and high cycles of one channel.
  task automatic measure(input int d, input int ch, input int exp_per,
                         input int exp_hi, input string tag);
    int n  = 0;
    int hi = 0;
    wait_ps(d, tag);
    do begin
      hi += int'(pwm_o[d][ch]);
      step();
      n++;
    end while (!ps_o[d] && n < 1200);
    check({tag, "_period"}, n, exp_per);
    check({tag, "_high"}, hi, exp_hi);
  endtask

  initial begin
    logic [5:0] acc;

    #1 RST = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_pwm%0d", d), int'(pwm_o[d]), 0);
      check($sformatf("rst_ps%0d", d), int'(ps_o[d]), 0);
    end
    @(negedge CLK);
    RST = 1'b0;
    CE  = 1'b1;

    // Basic duties, including 0 and MAX.
    wr(4, 40);
    wr(5, 200);
    wr(0, 2);
    wr(1, 0);
    wr(2, 255);
    measure(0, 0, 256, 2,   "edge_d2");
    measure(0, 2, 256, 255, "edge_dmax");
    measure(0, 1, 256, 0,   "edge_d0");
    measure(0, 3, 256, 0,   "edge_unwritten");
    measure(2, 4, 256, 40,  "six_ch4");
    measure(2, 5, 256, 200, "six_ch5");

    // Mid-period write, then a write coinciding with the reload edge.
    wait_ticks(0, 100, "mid");
    wr(0, 128);
    wait_ticks(0, 255, "edge");
    wr(0, 77);
    measure(0, 0, 256, 128, "pre_edge_shadow");
    measure(0, 0, 256, 77,  "edge_write");

    // Asynchronous reset between clock edges while ch0 is high.
    wait_ticks(0, 57, "rst_pt");
    #2;
    check("pre_rst_hi", int'(pwm_o[0][0]), 1);
    RST = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("async_rst_pwm%0d", d), int'(pwm_o[d]), 0);
      check($sformatf("async_rst_ps%0d", d), int'(ps_o[d]), 0);
    end
    @(negedge CLK);
    RST = 1'b0;

    // Selects 6 and 7 are out of range for the six-channel instance.
    wr(6, 99);
    wr(7, 150);
    acc = '0;
    for (int k = 0; k < 600; k++) begin
      acc |= pwm_o[2];
      step();
    end
    check("invalid_sel_quiet", int'(acc), 0);

    // Centre-aligned mode.
    wr(0, 64);
    wr(1, 255);
    sync(1, "ctr_sync");
    measure(1, 0, 510, 127, "ctr_d64");
    measure(1, 1, 510, 509, "ctr_dmax");

    // Alternating CE doubles period and high time.
    wr(0, 2);
    ce_tog = 1'b1;
    sync(0, "ce_sync");
    measure(0, 0, 512, 4, "ce_half");
    ce_tog = 1'b0;
    CE     = 1'b1;

    // Freeze with ch0 high, writing ch3 during the freeze.
    wait_ticks(0, 1, "frz");
    CE = 1'b0;
    for (int k = 0; k < 25; k++) step();
    wr(3, 200);
    for (int k = 0; k < 24; k++) step();
    check("freeze_hi", int'(pwm_o[0][0]), 1);
    CE = 1'b1;
    sync(0, "frz_sync");
    measure(0, 3, 256, 200, "frz_write");

    // Randomised traffic, including invalid selects and boundary duties.
    for (int k = 0; k < 3000; k++) begin
      CE = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) begin
        sel  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
          0:       D = 8'd0;
          1:       D = 8'd255;
          2:       D = 8'd1;
          3:       D = 8'd254;
          default: D = 8'($urandom);
        endcase
        D_WR = 1'b1;
      end else begin
        D_WR = 1'b0;
      end
      step();
    end
    D_WR = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
